axis_blk_hdr_rx: RTL and testbench

AXI4-Stream slave that collects one 80-byte Bitcoin block header, sent as twenty 32-bit words, and holds it as parallel fields for the miner core. It sits between the stream source (DMA or VIP master) and the `bitcoin_miner` core inside `bitcoin_miner_top`. It presents a complete header with a valid/ready handshake and back-pressures the stream until the core takes it.

---
 rtl/miner_axis_pkg.sv | 21 ++
 rtl/axis_blk_hdr_rx.sv | 152 +++++++++++++++
 tb/tb_axis_blk_hdr_rx.sv | 324 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/miner_axis_pkg.sv
// Shared constants and types for the miner AXI4-Stream front end.
// Word indices follow the 80-byte Bitcoin block header layout in 32-bit words.
package miner_axis_pkg;

  localparam int HDR_WORDS = 20;
  localparam int WCNT_W    = 5;

  localparam logic [WCNT_W-1:0] VERSION_IDX = 5'd0;
  localparam logic [WCNT_W-1:0] PREV_IDX    = 5'd1;
  localparam logic [WCNT_W-1:0] MERKLE_IDX  = 5'd9;
  localparam logic [WCNT_W-1:0] TIME_IDX    = 5'd17;
  localparam logic [WCNT_W-1:0] NBITS_IDX   = 5'd18;
  localparam logic [WCNT_W-1:0] NONCE_IDX   = WCNT_W'(HDR_WORDS - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    COLLECT = 2'd1,
    HOLD    = 2'd2
  } hdr_rx_state_t;

endpackage

// File: rtl/axis_blk_hdr_rx.sv
// AXI4-Stream slave collecting a 20-word block header into parallel fields.
// Optional TLAST framing check enabled by defining AXIS_HDR_TLAST_CHECK_EN.
//
// state   | meaning
// IDLE    | wcnt=0, waiting for header word 0
// COLLECT | accepting words 1..19
// HOLD    | header complete, hdr_valid=1, stream stalled until hdr_ready
module axis_blk_hdr_rx
  import miner_axis_pkg::*;
#(
  parameter int DATA_WIDTH = 32
) (
  input  logic                  aclk,
  input  logic                  areset,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [31:0]           blk_version,
  output logic [255:0]          prev_blk_header_hash,
  output logic [255:0]          merkle_root_hash,
  output logic [31:0]           blk_time,
  output logic [31:0]           blk_nbits,
  output logic [31:0]           blk_nonce,
  output logic                  hdr_valid,
  input  logic                  hdr_ready,
  output logic [7:0]            hdr_err_cnt
);

  generate
    if (DATA_WIDTH != 32) begin : g_bad_width
      $error("axis_blk_hdr_rx supports DATA_WIDTH=32 only");
    end
  endgenerate

  hdr_rx_state_t     state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic              xfer;
  logic              frame_err;
  logic              load_en;

  logic [31:0]       version_q, time_q, nbits_q, nonce_q;
  logic [7:0][31:0]  prev_q, merkle_q;
  logic [2:0]        prev_j, merkle_j;

  assign s_axis_tready = !areset && (state_q != HOLD);
  assign hdr_valid     = (state_q == HOLD);
  assign xfer          = s_axis_tvalid && s_axis_tready;

`ifdef AXIS_HDR_TLAST_CHECK_EN
  logic [7:0] err_cnt_q;

  // TLAST must be set on the nonce word and only there.
  assign frame_err   = xfer && (s_axis_tlast != (wcnt_q == NONCE_IDX));
  assign hdr_err_cnt = err_cnt_q;

  always_ff @(posedge aclk) begin
    if (areset) begin
      err_cnt_q <= '0;
    end else if (frame_err && (err_cnt_q != 8'hFF)) begin
      err_cnt_q <= err_cnt_q + 8'd1;
    end
  end
`else
  logic unused_tlast;

  assign unused_tlast = s_axis_tlast;
  assign frame_err    = 1'b0;
  assign hdr_err_cnt  = '0;
`endif

  always_ff @(posedge aclk) begin
    if (areset) begin
      state_q <= IDLE;
      wcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    load_en = 1'b0;
    case (state_q)
      IDLE, COLLECT: begin
        if (xfer) begin
          if (frame_err) begin
            state_d = IDLE;
            wcnt_d  = '0;
          end else begin
            load_en = 1'b1;
            if (wcnt_q == NONCE_IDX) begin
              state_d = HOLD;
            end else begin
              state_d = COLLECT;
              wcnt_d  = wcnt_q + 5'd1;
            end
          end
        end
      end
      HOLD: begin
        if (hdr_ready) begin
          state_d = IDLE;
          wcnt_d  = '0;
        end
      end
      default: begin
        state_d = IDLE;
        wcnt_d  = '0;
      end
    endcase
  end

  // First word of a hash field lands in the most significant slot.
  assign prev_j   = 3'(wcnt_q - PREV_IDX);
  assign merkle_j = 3'(wcnt_q - MERKLE_IDX);

  always_ff @(posedge aclk) begin
    if (areset) begin
      version_q <= '0;
      prev_q    <= '0;
      merkle_q  <= '0;
      time_q    <= '0;
      nbits_q   <= '0;
      nonce_q   <= '0;
    end else if (load_en) begin
      if (wcnt_q == VERSION_IDX) begin
        version_q <= s_axis_tdata;
      end else if (wcnt_q < MERKLE_IDX) begin
        prev_q[3'd7 - prev_j] <= s_axis_tdata;
      end else if (wcnt_q < TIME_IDX) begin
        merkle_q[3'd7 - merkle_j] <= s_axis_tdata;
      end else if (wcnt_q == TIME_IDX) begin
        time_q <= s_axis_tdata;
      end else if (wcnt_q == NBITS_IDX) begin
        nbits_q <= s_axis_tdata;
      end else begin
        nonce_q <= s_axis_tdata;
      end
    end
  end

  assign blk_version          = version_q;
  assign prev_blk_header_hash = prev_q;
  assign merkle_root_hash     = merkle_q;
  assign blk_time             = time_q;
  assign blk_nbits            = nbits_q;
  assign blk_nonce            = nonce_q;

endmodule

// File: tb/tb_axis_blk_hdr_rx.sv
// Scoreboard bench for axis_blk_hdr_rx: stream words feed a header-level model,
// completed headers are queued and compared while the DUT holds them.
module tb_axis_blk_hdr_rx;

  logic         aclk = 1'b0;
  logic         areset;
  logic [31:0]  s_axis_tdata;
  logic         s_axis_tvalid;
  logic         s_axis_tready;
  logic         s_axis_tlast;
  logic [31:0]  blk_version;
  logic [255:0] prev_blk_header_hash;
  logic [255:0] merkle_root_hash;
  logic [31:0]  blk_time;
  logic [31:0]  blk_nbits;
  logic [31:0]  blk_nonce;
  logic         hdr_valid;
  logic         hdr_ready;
  logic [7:0]   hdr_err_cnt;

  axis_blk_hdr_rx #(.DATA_WIDTH(32)) dut (
    .aclk                 (aclk),
    .areset               (areset),
    .s_axis_tdata         (s_axis_tdata),
    .s_axis_tvalid        (s_axis_tvalid),
    .s_axis_tready        (s_axis_tready),
    .s_axis_tlast         (s_axis_tlast),
    .blk_version          (blk_version),
    .prev_blk_header_hash (prev_blk_header_hash),
    .merkle_root_hash     (merkle_root_hash),
    .blk_time             (blk_time),
    .blk_nbits            (blk_nbits),
    .blk_nonce            (blk_nonce),
    .hdr_valid            (hdr_valid),
    .hdr_ready            (hdr_ready),
    .hdr_err_cnt          (hdr_err_cnt)
  );

  always #5 aclk = ~aclk;

  typedef struct packed {
    logic [31:0]  version;
    logic [255:0] prev;
    logic [255:0] merkle;
    logic [31:0]  tim;
    logic [31:0]  nbits;
    logic [31:0]  nonce;
  } hdr_t;

  int   checks = 0;
  int   errors = 0;
  int   cyc    = 0;
  hdr_t exp_q[$];
  int   rise_q[$];
  bit   rdy_rand = 1'b0;
  int   gap_mode = 0;

`ifdef AXIS_HDR_TLAST_CHECK_EN
  localparam bit TLAST_CHK = 1'b1;
`else
  localparam bit TLAST_CHK = 1'b0;
`endif

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: header-level view of the stream, evaluated mid-cycle.
  initial begin : monitor
    int          wcount;
    bit          hold;
    bit          prev_hv;
    int          exp_err;
    logic [31:0] words[20];
    hdr_t        h;
    wcount  = 0;
    hold    = 1'b0;
    prev_hv = 1'b0;
    exp_err = 0;
    forever begin
      @(negedge aclk);
      cyc++;
      if (areset) begin
        chk("tready_in_reset", s_axis_tready, 1'b0);
        wcount  = 0;
        hold    = 1'b0;
        prev_hv = 1'b0;
        exp_err = 0;
        exp_q.delete();
        continue;
      end
      chk("tready", s_axis_tready, !hold);
      chk("hdr_valid", hdr_valid, hold);
      chk("err_cnt", hdr_err_cnt, exp_err[7:0]);
      if (hdr_valid && !prev_hv) rise_q.push_back(cyc);
      prev_hv = hdr_valid;
      if (hold) begin
        if (exp_q.size() == 0) begin
          chk("scoreboard_nonempty", 1'b0, 1'b1);
        end else begin
          h = exp_q[0];
          chk("blk_version", blk_version, h.version);
          chk("prev_hash", prev_blk_header_hash, h.prev);
          chk("merkle_root", merkle_root_hash, h.merkle);
          chk("blk_time", blk_time, h.tim);
          chk("blk_nbits", blk_nbits, h.nbits);
          chk("blk_nonce", blk_nonce, h.nonce);
        end
        if (hdr_ready) begin
          if (exp_q.size() != 0) void'(exp_q.pop_front());
          hold = 1'b0;
        end
      end else if (s_axis_tvalid) begin
        if (TLAST_CHK && (s_axis_tlast != (wcount == 19))) begin
          wcount = 0;
          if (exp_err < 255) exp_err++;
        end else begin
          words[wcount] = s_axis_tdata;
          wcount++;
          if (wcount == 20) begin
            h.version = words[0];
            h.prev    = '0;
            h.merkle  = '0;
            for (int i = 1; i <= 8; i++)  h.prev   = {h.prev[223:0], words[i]};
            for (int i = 9; i <= 16; i++) h.merkle = {h.merkle[223:0], words[i]};
            h.tim   = words[17];
            h.nbits = words[18];
            h.nonce = words[19];
            exp_q.push_back(h);
            hold   = 1'b1;
            wcount = 0;
          end
        end
      end
    end
  end

  always @(posedge aclk) begin
    if (rdy_rand) begin
      #1 hdr_ready = ($urandom_range(0, 3) == 0);
    end
  end

  task automatic next_cycle();
    @(posedge aclk);
    #1;
  endtask

  task automatic send_word(input logic [31:0] d, input logic last);
    int n;
    bit done;
    n    = 0;
    done = 1'b0;
    if (gap_mode == 1) begin
      while ((cyc % 8) < 2) begin
        s_axis_tvalid = 1'b0;
        next_cycle();
      end
    end else if (gap_mode == 2) begin
      s_axis_tvalid = 1'b0;
      repeat ($urandom_range(0, 2)) next_cycle();
    end
    s_axis_tdata  = d;
    s_axis_tlast  = last;
    s_axis_tvalid = 1'b1;
    while (!done) begin
      @(negedge aclk);
      done = s_axis_tready;
      next_cycle();
      n++;
      if (!done && n > 500) begin
        chk("send_word_timeout", 1'b0, 1'b1);
        done = 1'b1;
      end
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
  endtask

  task automatic send_hdr(input logic [31:0] w[20], input bit noise);
    logic last;
    for (int i = 0; i < 20; i++) begin
      last = (i == 19);
      if (noise && !TLAST_CHK && ($urandom_range(0, 3) == 0)) last = !last;
      send_word(w[i], last);
    end
  endtask

  task automatic rand_hdr(output logic [31:0] w[20]);
    for (int i = 0; i < 20; i++) w[i] = $urandom;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || hdr_valid) && n < 400) begin
      next_cycle();
      n++;
    end
    chk("drain_done", (n < 400), 1'b1);
  endtask

  initial begin : stimulus
    logic [31:0] nom[20];
    logic [31:0] w[20];
    int          r0;
    areset        = 1'b1;
    s_axis_tdata  = '0;
    s_axis_tvalid = 1'b0;
    s_axis_tlast  = 1'b0;
    hdr_ready     = 1'b0;
    nom = '{32'h02000000,
            32'h671D0E2F, 32'h1A3C5B7E, 32'h9D2F4A61, 32'h0C8B3E95,
            32'h57E2D1A0, 32'h33C4F8B2, 32'hE1F09A4C, 32'h00000000,
            32'h2CD900FC, 32'h8E41B7D3, 32'h5A6F0C29, 32'hC3B81E47,
            32'h719DA2F0, 32'h0B4E8C65, 32'hD2A7391B, 32'h45F4992E,
            32'h74749054, 32'h747B1B18, 32'h43F740C0};
    repeat (3) next_cycle();
    areset = 1'b0;
    @(negedge aclk);
    chk("rst_version", blk_version, 32'h0);
    chk("rst_prev", prev_blk_header_hash, 256'h0);
    chk("rst_merkle", merkle_root_hash, 256'h0);
    chk("rst_nonce", {blk_time, blk_nbits, blk_nonce}, 96'h0);
    chk("rst_tready", s_axis_tready, 1'b1);
    chk("rst_valid", hdr_valid, 1'b0);
    chk("rst_err", hdr_err_cnt, 8'h0);
    next_cycle();

    // Nominal header, continuous stream.
    hdr_ready = 1'b1;
    r0 = rise_q.size();
    send_hdr(nom, 1'b0);
    drain();
    chk("nominal_rises", rise_q.size() - r0, 1);

    // Back-pressure with junk data while the header is held.
    hdr_ready = 1'b0;
    rand_hdr(w);
    send_hdr(w, 1'b0);
    s_axis_tvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      s_axis_tdata = $urandom;
      next_cycle();
    end
    s_axis_tvalid = 1'b0;
    hdr_ready     = 1'b1;
    drain();
    rand_hdr(w);
    send_hdr(w, 1'b0);
    drain();

    // Oscillating source: 2 cycles idle, 6 offered.
    gap_mode = 1;
    send_hdr(nom, 1'b0);
    drain();
    gap_mode = 0;

    // Reset after 7 words, then a clean header.
    rand_hdr(w);
    for (int i = 0; i < 7; i++) send_word(w[i], 1'b0);
    areset = 1'b1;
    next_cycle();
    next_cycle();
    areset = 1'b0;
    r0 = rise_q.size();
    rand_hdr(w);
    send_hdr(w, 1'b0);
    drain();
    chk("reset_rises", rise_q.size() - r0, 1);

    // Back-to-back headers.
    r0 = rise_q.size();
    w[19] = 32'h00000001;
    send_hdr(w, 1'b0);
    w[19] = 32'h00000002;
    send_hdr(w, 1'b0);
    drain();
    chk("b2b_rises", rise_q.size() - r0, 2);
    if (rise_q.size() - r0 == 2)
      chk("b2b_spacing", rise_q[r0 + 1] - rise_q[r0], 21);

    // Randomized headers, gaps and hdr_ready delays.
    gap_mode = 2;
    rdy_rand = 1'b1;
    for (int n = 0; n < 15; n++) begin
      rand_hdr(w);
      send_hdr(w, 1'b1);
    end
    drain();
    rdy_rand = 1'b0;
    gap_mode = 0;
    next_cycle();
    hdr_ready = 1'b1;

`ifdef AXIS_HDR_TLAST_CHECK_EN
    areset = 1'b1;
    next_cycle();
    areset = 1'b0;
    r0 = rise_q.size();
    rand_hdr(w);
    for (int i = 0; i < 6; i++) send_word(w[i], (i == 5));
    next_cycle();
    chk("tlast_err_one", hdr_err_cnt, 8'd1);
    chk("tlast_no_valid", rise_q.size() - r0, 0);
    send_hdr(w, 1'b0);
    drain();
    chk("tlast_recover", rise_q.size() - r0, 1);
    for (int i = 0; i < 256; i++) send_word($urandom, 1'b1);
    next_cycle();
    chk("tlast_err_sat", hdr_err_cnt, 8'd255);
`endif

    repeat (5) next_cycle();
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
